// File: rtl/mem_responder.sv
// Word-addressed data RAM for the core's load/store path, with programmable wait states and a
// registered one-cycle ready strobe. Optional posted writes: MEM_RESPONDER_POSTED_WRITE_EN.
module mem_responder #(
  parameter int unsigned AW_WORDS    = 6,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  localparam int unsigned Depth  = 1 << AW_WORDS;
  localparam logic [3:0]  WaitLd = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

  state_t        r_state, w_state_d;
  logic [3:0]    r_cnt, w_cnt_d;
  logic          r_we;
  logic [31:0]   r_addr;
  logic          r_ready, r_err;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [Depth];

  logic          w_idle;
  logic          w_acc_we;
  logic [31:0]   w_acc_addr;
  logic [31:0]   w_off;
  logic [31:0]   w_word;
  logic [AW_WORDS-1:0] w_idx;
  logic          w_err;
  logic          w_accept;
  logic          w_post;
  logic          w_resp_d;
  logic [31:0]   w_rd_word;
  logic          w_mem_we;
  logic [AW_WORDS-1:0] w_mem_widx;
  logic [31:0]   w_mem_wdata;

  // Live inputs are only looked at in IDLE; afterwards the captured copies drive everything.
  assign w_idle     = (r_state == StIdle);
  assign w_acc_we   = w_idle ? i_we : r_we;
  assign w_acc_addr = w_idle ? i_addr : r_addr;

  assign w_off  = w_acc_addr - BASE_ADDR;
  assign w_word = w_off >> 2;
  assign w_idx  = w_word[AW_WORDS-1:0];
  assign w_err  = (w_acc_addr[1:0] != 2'b00) || (w_acc_addr < BASE_ADDR) ||
                  ((w_word >> AW_WORDS) != 32'd0);

`ifdef MEM_RESPONDER_POSTED_WRITE_EN
  localparam logic [3:0] PwLd = (WAIT_STATES == 0) ? 4'd1 : WaitLd;

  logic                r_pw_valid;
  logic [AW_WORDS-1:0] r_pw_idx;
  logic [31:0]         r_pw_data;
  logic [3:0]          r_pw_cnt;
  logic                w_pw_drain;

  // While a write is buffered only a legal read of that same word may be accepted.
  assign w_accept   = i_req && (!r_pw_valid || (!i_we && !w_err && (r_pw_idx == w_idx)));
  assign w_post     = i_we && !w_err;
  assign w_pw_drain = r_pw_valid && (r_pw_cnt == 4'd1);
  assign w_rd_word  = (r_pw_valid && (r_pw_idx == w_idx)) ? r_pw_data : r_mem[w_idx];

  assign w_mem_we    = w_pw_drain;
  assign w_mem_widx  = r_pw_idx;
  assign w_mem_wdata = r_pw_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pw_valid <= 1'b0;
      r_pw_idx   <= '0;
      r_pw_data  <= '0;
      r_pw_cnt   <= '0;
    end else if (w_idle && w_accept && w_post) begin
      r_pw_valid <= 1'b1;
      r_pw_idx   <= w_idx;
      r_pw_data  <= i_wdata;
      r_pw_cnt   <= PwLd;
    end else if (w_pw_drain) begin
      r_pw_valid <= 1'b0;
    end else if (r_pw_valid) begin
      r_pw_cnt   <= r_pw_cnt - 4'd1;
    end
  end
`else
  logic [31:0] r_wdata;

  assign w_accept  = i_req;
  assign w_post    = 1'b0;
  assign w_rd_word = r_mem[w_idx];

  // The RAM commits at the edge that ends the response cycle.
  assign w_mem_we    = (r_state == StResp) && r_we && !w_err;
  assign w_mem_widx  = w_idx;
  assign w_mem_wdata = r_wdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdata <= '0;
    end else if (w_idle && w_accept) begin
      r_wdata <= i_wdata;
    end
  end
`endif

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_cnt_d = WaitLd;
          if (w_post || (WAIT_STATES == 0)) w_state_d = StResp;
          else                              w_state_d = StWait;
        end
      end
      StWait: begin
        w_cnt_d = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_d = StResp;
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign w_resp_d = (w_state_d == StResp);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_idle && w_accept) begin
        r_we   <= i_we;
        r_addr <= i_addr;
      end
    end
  end

  // Outputs are loaded on the edge entering RESP so they are stable for the whole strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_resp_d;
      r_err   <= w_resp_d && w_err;
      r_rdata <= (w_resp_d && !w_err && !w_acc_we) ? w_rd_word : 32'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[w_mem_widx] <= w_mem_wdata;
  end

  assign o_ready = r_ready;
  assign o_err   = r_err;
  assign o_rdata = r_rdata;

endmodule
